// File: rtl/reset_stage_sequencer_if.sv
// Signal bundle between the reset stage sequencer and the reset domains it controls.
// The sequencer drives the master modport; the domains and software drive the slave modport.
interface reset_stage_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  // stage_ack is a level, not a pulse: the sequencer samples stage_ack[k] once per edge
  // only while it waits on stage k, and ignores that bit once it has been accepted.
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  seq_err;
  logic [2:0]            seq_state;

  modport master (
    input  soft_rst_req,
    input  stage_ack,
    output stage_rst_n,
    output seq_done,
    output seq_err,
    output seq_state
  );

  modport slave (
    output soft_rst_req,
    output stage_ack,
    input  stage_rst_n,
    input  seq_done,
    input  seq_err,
    input  seq_state
  );
endinterface

// File: rtl/reset_stage_sequencer.sv
// Releases downstream reset domains one at a time, each after a delay and the previous ack.
// Optional: define SOFT_RST_SYNC_EN to pass soft_rst_req through a 2-flop synchronizer.
module reset_stage_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  reset_stage_sequencer_if.master  bus
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_DELAY    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DONE     = 3'd3,
    S_HOLD     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CNT_W-1:0]      tcnt, tcnt_nxt;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;
  logic                  soft_req;
  logic                  ack_sel;

`ifdef SOFT_RST_SYNC_EN
  logic [1:0] soft_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) soft_sync <= 2'b00;
    else     soft_sync <= {soft_sync[0], bus.soft_rst_req};
  end
  assign soft_req = soft_sync[1];
`else
  assign soft_req = bus.soft_rst_req;
`endif

  assign ack_sel = bus.stage_ack[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_DELAY;
      idx     <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      tcnt    <= tcnt_nxt;
      rst_n_q <= rst_n_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    rst_n_nxt = rst_n_q;
    done_nxt  = done_q;
    err_nxt   = err_q;

    case (state)
      S_DELAY: begin
        if (cnt == DELAY_LAST) begin
          rst_n_nxt = rst_n_q | (NUM_STAGES'(1) << idx);
          tcnt_nxt  = '0;
          state_nxt = S_WAIT_ACK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (ack_sel) begin
          if (idx == IDX_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_DELAY;
          end
        end else if (tcnt == TIMEOUT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
      end
      S_HOLD: begin
        // The hold window only starts once software lets go of the request.
        if (soft_req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DELAY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_DELAY;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        tcnt_nxt  = '0;
      end
    endcase

    if (soft_req && (state != S_HOLD)) begin
      rst_n_nxt = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = S_HOLD;
    end
  end

  assign bus.stage_rst_n = rst_n_q;
  assign bus.seq_done    = done_q;
  assign bus.seq_err     = err_q;
  assign bus.seq_state   = state;
endmodule
